// File: rtl/sync_counter_pkg.sv
// sync_counter_pkg: direction encoding and terminal-value helper shared by the counter files
package sync_counter_pkg;
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
    function automatic logic [31:0] term_val(input longint unsigned modulus);
        return 32'(modulus - 64'd1);
    endfunction
endpackage

// File: rtl/param_sync_counter_if.sv
// param_sync_counter_if: control, load and status signals of one counter stage
interface param_sync_counter_if #(parameter int WIDTH = 4);
    logic             cnt_en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    modport master (output cnt_en, up, load, d, input q, tc, wrap);
    modport slave  (input cnt_en, up, load, d, output q, tc, wrap);
endinterface

// File: rtl/param_sync_counter_next.sv
// param_sync_counter_next: next count value, terminal count and wrap detection for one stage
module param_sync_counter_next
    import sync_counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             cnt_en,
    input  logic             up,
    input  logic             load,
    output logic [WIDTH-1:0] q_next,
    output logic             tc,
    output logic             wrap_next
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(term_val(MODULUS));
    logic             at_term;
    logic [WIDTH-1:0] stepped;
    // wrap comes from the terminal compare, so a full-range modulus needs no carry-out
    always_comb begin
        at_term   = (up == DIR_UP) ? (q == MAX) : (q == '0);
        stepped   = (up == DIR_UP) ? (at_term ? '0 : q + 1'b1) : (at_term ? MAX : q - 1'b1);
        tc        = cnt_en & at_term;
        q_next    = load ? ((d > MAX) ? MAX : d) : (cnt_en ? stepped : q);
        wrap_next = ~load & tc;
    end
endmodule

// File: rtl/param_sync_counter.sv
// param_sync_counter: cascadable up/down modulo counter with clamped load and wrap pulse
module param_sync_counter
    import sync_counter_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input logic                 clock,
    input logic                 clear,
    param_sync_counter_if.slave bus
);
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
        $fatal(1, "param_sync_counter: illegal WIDTH/MODULUS");
    end
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    param_sync_counter_next #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
        .q         (bus.q),
        .d         (bus.d),
        .cnt_en    (bus.cnt_en),
        .up        (bus.up),
        .load      (bus.load),
        .q_next    (q_next),
        .tc        (bus.tc),
        .wrap_next (wrap_next)
    );
    // count register and wrap pulse; clear overrides every other request
    always_ff @(posedge clock) begin
        bus.q    <= clear ? '0 : q_next;
        bus.wrap <= clear ? 1'b0 : wrap_next;
    end
endmodule

// File: tb/tb_param_sync_counter.sv
// tb_param_sync_counter: directed checks of single, cascaded and full-range counters
module tb_param_sync_counter;
    logic clock = 1'b0;
    logic clr10 = 1'b0;
    logic clrc  = 1'b0;
    logic clr16 = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    param_sync_counter_if #(.WIDTH(4)) if10 ();
    param_sync_counter_if #(.WIDTH(4)) iflo ();
    param_sync_counter_if #(.WIDTH(4)) ifhi ();
    param_sync_counter_if #(.WIDTH(4)) if16 ();

    assign ifhi.cnt_en = iflo.tc;

    param_sync_counter #(.WIDTH(4), .MODULUS(10)) u10 (.clock(clock), .clear(clr10), .bus(if10));
    param_sync_counter #(.WIDTH(4), .MODULUS(10)) ulo (.clock(clock), .clear(clrc),  .bus(iflo));
    param_sync_counter #(.WIDTH(4), .MODULUS(10)) uhi (.clock(clock), .clear(clrc),  .bus(ifhi));
    param_sync_counter #(.WIDTH(4), .MODULUS(16)) u16 (.clock(clock), .clear(clr16), .bus(if16));

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        clr10 = 1'b1; if10.load = 1'b1; if10.d = 4'd7; if10.cnt_en = 1'b1; if10.up = 1'b1;
        step();
        n_cmp++;
        if (if10.q !== 4'd0) begin n_fail++; $display("FAIL reset_q got=%0d exp=0", if10.q); end
        n_cmp++;
        if (if10.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", if10.wrap); end
        clr10 = 1'b0; if10.load = 1'b0; if10.cnt_en = 1'b0;
    endtask

    task automatic test_up;
        logic [3:0] exp_q;
        if10.up = 1'b1; if10.cnt_en = 1'b1;
        exp_q = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            n_cmp++;
            if (if10.tc !== (exp_q == 4'd9)) begin
                n_fail++; $display("FAIL up_tc q=%0d got=%b exp=%b", exp_q, if10.tc, exp_q == 4'd9);
            end
            step();
            exp_q = 4'(i % 10);
            n_cmp++;
            if (if10.q !== exp_q) begin n_fail++; $display("FAIL up_q edge=%0d got=%0d exp=%0d", i, if10.q, exp_q); end
            n_cmp++;
            if (if10.wrap !== (i == 10)) begin n_fail++; $display("FAIL up_wrap edge=%0d got=%b exp=%b", i, if10.wrap, i == 10); end
        end
        if10.cnt_en = 1'b0;
    endtask

    task automatic test_down;
        logic [3:0] exp_seq [4] = '{4'd9, 4'd8, 4'd7, 4'd6};
        if10.load = 1'b1; if10.d = 4'd0; if10.cnt_en = 1'b0; if10.up = 1'b1;
        step();
        n_cmp++;
        if (if10.q !== 4'd0) begin n_fail++; $display("FAIL down_load got=%0d exp=0", if10.q); end
        if10.load = 1'b0; if10.up = 1'b0; if10.cnt_en = 1'b1;
        #1;
        n_cmp++;
        if (if10.tc !== 1'b1) begin n_fail++; $display("FAIL down_tc_at0 got=%b exp=1", if10.tc); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (if10.q !== exp_seq[i]) begin n_fail++; $display("FAIL down_q step=%0d got=%0d exp=%0d", i, if10.q, exp_seq[i]); end
            n_cmp++;
            if (if10.wrap !== (i == 0)) begin n_fail++; $display("FAIL down_wrap step=%0d got=%b exp=%b", i, if10.wrap, i == 0); end
            n_cmp++;
            if (if10.tc !== 1'b0) begin n_fail++; $display("FAIL down_tc step=%0d got=%b exp=0", i, if10.tc); end
        end
        if10.cnt_en = 1'b0; if10.up = 1'b1;
    endtask

    task automatic test_clamp;
        if10.load = 1'b1; if10.d = 4'd9; if10.cnt_en = 1'b0; if10.up = 1'b1;
        step();
        n_cmp++;
        if (if10.tc !== 1'b0) begin n_fail++; $display("FAIL tc_no_en got=%b exp=0", if10.tc); end
        if10.d = 4'd12; if10.cnt_en = 1'b1;
        #1;
        n_cmp++;
        if (if10.tc !== 1'b1) begin n_fail++; $display("FAIL tc_en_at9 got=%b exp=1", if10.tc); end
        step();
        n_cmp++;
        if (if10.q !== 4'd9) begin n_fail++; $display("FAIL clamp_q got=%0d exp=9", if10.q); end
        n_cmp++;
        if (if10.wrap !== 1'b0) begin n_fail++; $display("FAIL clamp_wrap got=%b exp=0", if10.wrap); end
        if10.d = 4'd5; if10.cnt_en = 1'b0;
        step();
        n_cmp++;
        if (if10.q !== 4'd5) begin n_fail++; $display("FAIL load5_q got=%0d exp=5", if10.q); end
        if10.load = 1'b0;
        step();
        step();
        n_cmp++;
        if (if10.q !== 4'd5) begin n_fail++; $display("FAIL hold_q got=%0d exp=5", if10.q); end
        n_cmp++;
        if (if10.wrap !== 1'b0) begin n_fail++; $display("FAIL hold_wrap got=%b exp=0", if10.wrap); end
    endtask

    task automatic test_cascade;
        logic [3:0] exp_lo, exp_hi;
        clrc = 1'b1; iflo.cnt_en = 1'b1; iflo.up = 1'b1; iflo.load = 1'b0; iflo.d = 4'd0;
        ifhi.up = 1'b1; ifhi.load = 1'b0; ifhi.d = 4'd0;
        step();
        clrc = 1'b0;
        n_cmp++;
        if ({ifhi.q, iflo.q} !== 8'h00) begin n_fail++; $display("FAIL casc_clear got=%h exp=00", {ifhi.q, iflo.q}); end
        for (int i = 1; i <= 100; i++) begin
            step();
            exp_lo = 4'(i % 10);
            exp_hi = 4'((i / 10) % 10);
            n_cmp++;
            if ({ifhi.q, iflo.q} !== {exp_hi, exp_lo}) begin
                n_fail++; $display("FAIL casc_bcd edge=%0d got=%h exp=%h", i, {ifhi.q, iflo.q}, {exp_hi, exp_lo});
            end
        end
        n_cmp++;
        if (ifhi.wrap !== 1'b1) begin n_fail++; $display("FAIL casc_hi_wrap got=%b exp=1", ifhi.wrap); end
        iflo.cnt_en = 1'b0;
    endtask

    task automatic test_mod16;
        clr16 = 1'b1; if16.load = 1'b0; if16.d = 4'd0; if16.cnt_en = 1'b0; if16.up = 1'b1;
        step();
        clr16 = 1'b0; if16.load = 1'b1; if16.d = 4'd15;
        step();
        n_cmp++;
        if (if16.q !== 4'd15) begin n_fail++; $display("FAIL m16_load got=%0d exp=15", if16.q); end
        if16.load = 1'b0; if16.cnt_en = 1'b1;
        #1;
        n_cmp++;
        if (if16.tc !== 1'b1) begin n_fail++; $display("FAIL m16_tc got=%b exp=1", if16.tc); end
        step();
        n_cmp++;
        if (if16.q !== 4'd0) begin n_fail++; $display("FAIL m16_wrap_q got=%0d exp=0", if16.q); end
        n_cmp++;
        if (if16.wrap !== 1'b1) begin n_fail++; $display("FAIL m16_wrap got=%b exp=1", if16.wrap); end
        for (int i = 1; i <= 6; i++) step();
        n_cmp++;
        if (if16.q !== 4'd6) begin n_fail++; $display("FAIL m16_run got=%0d exp=6", if16.q); end
        n_cmp++;
        if (if16.wrap !== 1'b0) begin n_fail++; $display("FAIL m16_run_wrap got=%b exp=0", if16.wrap); end
        clr16 = 1'b1;
        step();
        n_cmp++;
        if (if16.q !== 4'd0) begin n_fail++; $display("FAIL m16_abort got=%0d exp=0", if16.q); end
        clr16 = 1'b0;
        step();
        n_cmp++;
        if (if16.q !== 4'd1) begin n_fail++; $display("FAIL m16_resume got=%0d exp=1", if16.q); end
        if16.up = 1'b0; if16.load = 1'b1; if16.d = 4'd0; if16.cnt_en = 1'b0;
        step();
        if16.load = 1'b0; if16.cnt_en = 1'b1;
        step();
        n_cmp++;
        if (if16.q !== 4'd15) begin n_fail++; $display("FAIL m16_down_wrap_q got=%0d exp=15", if16.q); end
        n_cmp++;
        if (if16.wrap !== 1'b1) begin n_fail++; $display("FAIL m16_down_wrap got=%b exp=1", if16.wrap); end
    endtask

    initial begin
        if10.cnt_en = 1'b0; if10.up = 1'b1; if10.load = 1'b0; if10.d = '0;
        iflo.cnt_en = 1'b0; iflo.up = 1'b1; iflo.load = 1'b0; iflo.d = '0;
        ifhi.up = 1'b1; ifhi.load = 1'b0; ifhi.d = '0;
        if16.cnt_en = 1'b0; if16.up = 1'b1; if16.load = 1'b0; if16.d = '0;
        #2;
        test_reset();
        test_up();
        test_down();
        test_clamp();
        test_cascade();
        test_mod16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
